// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory port arbiter: FSM encoding and requester IDs.
// Latency: n/a. Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int REQ_CORE = 0;
   localparam int REQ_DBG  = 1;

   function automatic logic [1:0] id_to_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
// Latency: combinational. Backpressure: none, pure function of valid/last.
module rr_arbiter_2
   import mem_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid[REQ_CORE] && valid[REQ_DBG]) begin
         // last holds the index of the previous winner
         grant = last ? 2'b01 : 2'b10;
      end else begin
         grant = valid;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle data memory port between the core and the debug/loader.
// Latency: accept N, memory strobe N+1, response N+2. Backpressure: ready only in IDLE.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              req_valid_i,
   input  logic [1:0]              req_write_i,
   input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
   output logic [1:0]              req_ready_o,
   output logic [1:0]              rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    mem_read_o,
   output logic                    mem_write_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   arb_state_t            state_q;
   arb_state_t            state_d;
   logic                  last_q;
   logic                  own_q;
   logic                  wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            grant;
   logic                  accept;
   logic                  sel;

   rr_arbiter_2 u_rr (
      .valid (req_valid_i),
      .last  (last_q),
      .grant (grant)
   );

   assign sel = grant[REQ_DBG];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes are gated with reset so an in-flight access is dropped immediately.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid_i) begin
               accept  = 1'b1;
               state_d = ACCESS;
               if (!reset) begin
                  req_ready_o = grant;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (!reset) begin
               mem_read_o  = ~wr_q;
               mem_write_o = wr_q;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (!reset) begin
               rsp_valid_o = id_to_onehot(own_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q  <= 1'b1;
         own_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            last_q  <= sel;
            own_q   <= sel;
            wr_q    <= req_write_i[sel];
            addr_q  <= sel ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
            wdata_q <= sel ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
         end
         if (state_q == ACCESS) begin
            rdata_q <= wr_q ? '0 : mem_rdata_i;
         end
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign rsp_rdata_o = rdata_q;

endmodule
